uart_recv: RTL and testbench

//  8N1 UART receiver; the RX-side counterpart of uart_send. Uses the same baud parameters.

---
 rtl/uart_recv_pkg.sv | 23 ++
 rtl/uart_bit_sync.sv | 23 ++
 rtl/uart_recv.sv | 112 +++++++++++
 tb/tb_uart_recv.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_recv_pkg.sv
// Shared UART definitions: receiver FSM encoding and baud-timer derivation.
package uart_recv_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitIdle
  } rx_state_e;

  localparam int unsigned DefaultDataBits = 8;

  // Clocks per bit; integer divide, so the baud error is the caller's to accept.
  function automatic int unsigned bps_cnt(input int unsigned clk_freq, input int unsigned baud);
    return clk_freq / baud;
  endfunction

  function automatic int unsigned bps_half(input int unsigned clk_freq, input int unsigned baud);
    return bps_cnt(clk_freq, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_bit_sync.sv
// N-stage single-bit synchroniser; resets to 1 so an idle-high line shows no edge out of reset.
module uart_bit_sync #(
  parameter int unsigned Stages = 2
) (
  input  logic clk,
  input  logic sys_rst_n,
  input  logic data_i,
  output logic data_o
);

  logic [Stages-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!sys_rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[Stages-2:0], data_i};
    end
  end

  assign data_o = sync_q[Stages-1];

endmodule

// File: rtl/uart_recv.sv
// 8N1 UART receiver: synchronises uart_rxd, samples each bit mid-bit and
// presents the byte with a one-cycle done strobe (or a frame-error strobe).
module uart_recv
  import uart_recv_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned UART_BPS  = 115200,
  parameter int unsigned DATA_BITS = DefaultDataBits
) (
  input  logic                 clk,
  input  logic                 sys_rst_n,
  input  logic                 uart_rxd,
  output logic [DATA_BITS-1:0] uart_data,
  output logic                 uart_done,
  output logic                 uart_frame_err,
  output logic                 uart_rx_busy
);

  localparam int unsigned BpsCnt = bps_cnt(CLK_FREQ, UART_BPS);
  localparam int unsigned Half   = bps_half(CLK_FREQ, UART_BPS);
  localparam int unsigned CntW   = $clog2(BpsCnt);
  localparam int unsigned IdxW   = $clog2(DATA_BITS + 1);

  rx_state_e            state_q;
  logic [CntW-1:0]      cnt_q;
  logic [IdxW-1:0]      bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 rx_s;
  logic                 rx_d_q;
  logic                 fall;
  logic                 at_smp;
  logic                 at_bnd;

  uart_bit_sync #(
    .Stages(2)
  ) u_sync (
    .clk      (clk),
    .sys_rst_n(sys_rst_n),
    .data_i   (uart_rxd),
    .data_o   (rx_s)
  );

  assign fall   = rx_d_q & ~rx_s;
  assign at_smp = (cnt_q == CntW'(Half));
  assign at_bnd = (cnt_q == CntW'(BpsCnt - 1));

  always_ff @(posedge clk) begin
    if (!sys_rst_n) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      bit_idx_q      <= '0;
      shift_q        <= '0;
      rx_d_q         <= 1'b1;
      uart_data      <= '0;
      uart_done      <= 1'b0;
      uart_frame_err <= 1'b0;
    end else begin
      rx_d_q         <= rx_s;
      uart_done      <= 1'b0;
      uart_frame_err <= 1'b0;
      cnt_q          <= at_bnd ? '0 : cnt_q + CntW'(1);
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (fall) state_q <= StStart;
        end
        StStart: begin
          if (at_smp && rx_s) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else if (at_bnd) begin
            state_q   <= StData;
            bit_idx_q <= '0;
          end
        end
        StData: begin
          // LSB arrives first, so shifting right leaves bit i in shift_q[i] after the last bit.
          if (at_smp) shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
          if (at_bnd) begin
            bit_idx_q <= bit_idx_q + IdxW'(1);
            if (bit_idx_q == IdxW'(DATA_BITS - 1)) state_q <= StStop;
          end
        end
        StStop: begin
          // Leave at mid-stop so a back-to-back start edge is not missed.
          if (at_smp) begin
            cnt_q <= '0;
            if (rx_s) begin
              uart_data <= shift_q;
              uart_done <= 1'b1;
              state_q   <= StIdle;
            end else begin
              uart_frame_err <= 1'b1;
              state_q        <= StWaitIdle;
            end
          end
        end
        StWaitIdle: begin
          cnt_q <= '0;
          if (rx_s) state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign uart_rx_busy = (state_q != StIdle);

endmodule

// File: tb/tb_uart_recv.sv
// Directed bench for uart_recv at 10 clk per bit (HALF = 5).
module tb_uart_recv;

  localparam int unsigned Bit = 10;

  logic       clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       uart_rxd = 1'b1;
  logic [7:0] uart_data;
  logic       uart_done;
  logic       uart_frame_err;
  logic       uart_rx_busy;

  int vectors = 0;
  int miscompares = 0;

  int cyc = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int overlap = 0;
  int consec = 0;
  logic prev_pulse = 1'b0;
  logic [7:0] data_q[$];

  uart_recv #(
    .CLK_FREQ (50_000_000),
    .UART_BPS (5_000_000),
    .DATA_BITS(8)
  ) dut (
    .clk           (clk),
    .sys_rst_n     (sys_rst_n),
    .uart_rxd      (uart_rxd),
    .uart_data     (uart_data),
    .uart_done     (uart_done),
    .uart_frame_err(uart_frame_err),
    .uart_rx_busy  (uart_rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (uart_done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
      data_q.push_back(uart_data);
    end
    if (uart_frame_err) err_cnt = err_cnt + 1;
    if (uart_done && uart_frame_err) overlap = overlap + 1;
    if ((uart_done || uart_frame_err) && prev_pulse) consec = consec + 1;
    prev_pulse = uart_done || uart_frame_err;
  end

  // Drives one full frame starting on a negedge; returns at the end of the stop bit.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    start_cyc = cyc;
    uart_rxd = 1'b0;
    repeat (Bit) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (Bit) @(negedge clk);
    end
    uart_rxd = stop;
    repeat (Bit) @(negedge clk);
  endtask

  task automatic idle(input int n);
    uart_rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors += 4;
    if (uart_data !== 8'h00) begin
      miscompares++; $display("FAIL reset_data: got %h want 00", uart_data);
    end
    if (uart_done !== 1'b0) begin
      miscompares++; $display("FAIL reset_done: got %b want 0", uart_done);
    end
    if (uart_frame_err !== 1'b0) begin
      miscompares++; $display("FAIL reset_err: got %b want 0", uart_frame_err);
    end
    if (uart_rx_busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_busy: got %b want 0", uart_rx_busy);
    end
    sys_rst_n = 1'b1;
    idle(5);
  endtask

  task automatic test_single();
    int d0 = done_cnt;
    int e0 = err_cnt;
    data_q.delete();
    send_frame(8'hAA, 1'b1);
    idle(10);
    vectors += 4;
    if (done_cnt - d0 !== 1) begin
      miscompares++; $display("FAIL single_done_count: got %0d want 1", done_cnt - d0);
    end
    if (data_q.size() != 1 || data_q[0] !== 8'hAA) begin
      miscompares++; $display("FAIL single_data: got %h want aa", uart_data);
    end
    if (err_cnt - e0 !== 0) begin
      miscompares++; $display("FAIL single_err: got %0d want 0", err_cnt - e0);
    end
    if (done_cyc - start_cyc !== 99) begin
      miscompares++; $display("FAIL single_latency: got %0d want 99", done_cyc - start_cyc);
    end
  endtask

  task automatic test_stream();
    logic [7:0] exp [3];
    exp[0] = 8'h00; exp[1] = 8'hFF; exp[2] = 8'h5A;
    data_q.delete();
    for (int i = 0; i < 3; i++) begin
      send_frame(exp[i], 1'b1);
      idle(Bit);
    end
    vectors++;
    if (data_q.size() != 3) begin
      miscompares++; $display("FAIL stream_count: got %0d want 3", data_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (data_q[i] !== exp[i]) begin
          miscompares++; $display("FAIL stream_byte%0d: got %h want %h", i, data_q[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    data_q.delete();
    send_frame(8'h55, 1'b1);
    send_frame(8'hC3, 1'b1);
    idle(10);
    vectors += 2;
    if (data_q.size() != 2) begin
      miscompares++; $display("FAIL b2b_count: got %0d want 2", data_q.size());
    end else if (data_q[0] !== 8'h55 || data_q[1] !== 8'hC3) begin
      miscompares++; $display("FAIL b2b_data: got %h %h want 55 c3", data_q[0], data_q[1]);
    end
    if (uart_data !== 8'hC3) begin
      miscompares++; $display("FAIL b2b_hold: got %h want c3", uart_data);
    end
  endtask

  task automatic test_glitch();
    int d0 = done_cnt;
    int e0 = err_cnt;
    uart_rxd = 1'b0;
    repeat (3) @(negedge clk);
    uart_rxd = 1'b1;
    vectors++;
    if (uart_rx_busy !== 1'b1) begin
      miscompares++; $display("FAIL glitch_busy_hi: got %b want 1", uart_rx_busy);
    end
    repeat (10) @(negedge clk);
    vectors += 3;
    if (uart_rx_busy !== 1'b0) begin
      miscompares++; $display("FAIL glitch_busy_lo: got %b want 0", uart_rx_busy);
    end
    if ((done_cnt - d0) + (err_cnt - e0) !== 0) begin
      miscompares++;
      $display("FAIL glitch_pulses: got done %0d err %0d want 0 0", done_cnt - d0, err_cnt - e0);
    end
    if (uart_data !== 8'hC3) begin
      miscompares++; $display("FAIL glitch_data: got %h want c3", uart_data);
    end
    idle(100);
  endtask

  task automatic test_frame_err();
    int d0 = done_cnt;
    int e0 = err_cnt;
    send_frame(8'h3C, 1'b0);
    repeat (20) @(negedge clk);
    vectors++;
    if (uart_rx_busy !== 1'b1) begin
      miscompares++; $display("FAIL ferr_break_busy: got %b want 1", uart_rx_busy);
    end
    idle(20);
    vectors += 4;
    if (err_cnt - e0 !== 1) begin
      miscompares++; $display("FAIL ferr_count: got %0d want 1", err_cnt - e0);
    end
    if (done_cnt - d0 !== 0) begin
      miscompares++; $display("FAIL ferr_done: got %0d want 0", done_cnt - d0);
    end
    if (uart_data !== 8'hC3) begin
      miscompares++; $display("FAIL ferr_data_hold: got %h want c3", uart_data);
    end
    send_frame(8'h81, 1'b1);
    idle(10);
    if (done_cnt - d0 !== 1 || uart_data !== 8'h81) begin
      miscompares++;
      $display("FAIL ferr_recover: got %0d pulses data %h want 1 81", done_cnt - d0, uart_data);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b = 8'hF0;
    int d0;
    int e0;
    uart_rxd = 1'b0;
    repeat (Bit) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      uart_rxd = b[i];
      repeat (Bit) @(negedge clk);
    end
    uart_rxd = b[4];
    repeat (5) @(negedge clk);
    sys_rst_n = 1'b0;
    @(negedge clk);
    vectors += 2;
    if (uart_data !== 8'h00 || uart_done !== 1'b0 || uart_frame_err !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs: got data %h done %b err %b want 00 0 0",
               uart_data, uart_done, uart_frame_err);
    end
    if (uart_rx_busy !== 1'b0) begin
      miscompares++; $display("FAIL rst_mid_busy: got %b want 0", uart_rx_busy);
    end
    @(negedge clk);
    sys_rst_n = 1'b1;
    d0 = done_cnt;
    e0 = err_cnt;
    repeat (3) @(negedge clk);
    for (int i = 5; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (Bit) @(negedge clk);
    end
    uart_rxd = 1'b1;
    repeat (Bit) @(negedge clk);
    idle(20);
    vectors++;
    if ((done_cnt - d0) + (err_cnt - e0) !== 0) begin
      miscompares++;
      $display("FAIL rst_mid_pulses: got done %0d err %0d want 0 0", done_cnt - d0, err_cnt - e0);
    end
    send_frame(8'h7E, 1'b1);
    idle(10);
    vectors++;
    if (done_cnt - d0 !== 1 || uart_data !== 8'h7E) begin
      miscompares++;
      $display("FAIL rst_mid_next: got %0d pulses data %h want 1 7e", done_cnt - d0, uart_data);
    end
  endtask

  task automatic test_invariants();
    vectors += 2;
    if (overlap !== 0) begin
      miscompares++; $display("FAIL inv_overlap: got %0d want 0", overlap);
    end
    if (consec !== 0) begin
      miscompares++; $display("FAIL inv_consecutive: got %0d want 0", consec);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_stream();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_midframe();
    test_invariants();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
